// File: rtl/aes_pkg.sv
// AES constants, S-box table and GF(2^8) helpers shared by the
// encrypt and decrypt cores.
package aes_pkg;

  localparam int NR = 14;

  typedef logic [0:15][7:0] state_t;
  typedef logic [31:0]      word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_DONE
  } enc_fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Index 0 is unused so that Rcon[i] matches the usual 1-based numbering.
  localparam logic [7:0] RCON [8] = '{
    8'h00, 8'h01, 8'h02, 8'h04,
    8'h08, 8'h10, 8'h20, 8'h40
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: one byte in, one byte out, purely combinational.
// Looked up from the shared table so encrypt and decrypt agree.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = SBOX[a];

endmodule

// File: rtl/aes256_encrypt_iter.sv
// Iterative AES-256 encryptor, one round per clock, keys expanded on the fly.
// Define AES256_ENC_ABORT_EN to add the abort input.
module aes256_encrypt_iter
  import aes_pkg::*;
(
  input  logic         enable,
  input  logic         reset,
  input  logic         start,
`ifdef AES256_ENC_ABORT_EN
  input  logic         abort,
`endif
  input  logic [127:0] plaintext,
  input  logic [255:0] key,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
);

  enc_fsm_t     fsm_q, fsm_d;
  state_t       st_q, st_d;
  logic [127:0] kp_q, kp_d;
  logic [127:0] kc_q, kc_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] ct_q, ct_d;
  logic         abort_req;

`ifdef AES256_ENC_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  state_t sb, sr, mc, rout;
  logic   last;

  for (genvar i = 0; i < 16; i++) begin : g_dsb
    aes_sbox u_sb (
      .a (st_q[i]),
      .y (sb[i])
    );
  end

  always_comb begin
    sr = '0;
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ gmul3(sr[4*c+1])
                ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1])
                ^ gmul3(sr[4*c+2]) ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1]
                ^ xtime(sr[4*c+2]) ^ gmul3(sr[4*c+3]);
      mc[4*c+3] = gmul3(sr[4*c]) ^ sr[4*c+1]
                ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
  end

  assign last = (rnd_q == 4'(NR));
  assign rout = (last ? sr : mc) ^ kc_q;

  // Odd r means K(r+1) has an even index: rotate and apply Rcon.
  word_t      kw3, ksel, ksub, rcw;
  word_t      kn0, kn1, kn2, kn3;
  logic [2:0] rc_idx;

  assign kw3    = kc_q[31:0];
  assign ksel   = rnd_q[0] ? {kw3[23:0], kw3[31:24]} : kw3;
  assign rc_idx = rnd_q[3:1] + 3'd1;
  assign rcw    = rnd_q[0] ? {RCON[rc_idx], 24'h0} : '0;

  for (genvar j = 0; j < 4; j++) begin : g_ksb
    aes_sbox u_sb (
      .a (ksel[8*j +: 8]),
      .y (ksub[8*j +: 8])
    );
  end

  assign kn0 = kp_q[127:96] ^ ksub ^ rcw;
  assign kn1 = kp_q[95:64] ^ kn0;
  assign kn2 = kp_q[63:32] ^ kn1;
  assign kn3 = kp_q[31:0] ^ kn2;

  always_comb begin
    fsm_d = fsm_q;
    st_d  = st_q;
    kp_d  = kp_q;
    kc_d  = kc_q;
    rnd_d = rnd_q;
    ct_d  = ct_q;
    unique case (fsm_q)
      S_IDLE: begin
        if (start) begin
          st_d  = plaintext ^ key[255:128];
          kp_d  = key[255:128];
          kc_d  = key[127:0];
          rnd_d = 4'd1;
          fsm_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (abort_req) begin
          fsm_d = S_IDLE;
          rnd_d = 4'd0;
        end else begin
          st_d = rout;
          kp_d = kc_q;
          kc_d = {kn0, kn1, kn2, kn3};
          if (last) begin
            ct_d  = rout;
            rnd_d = 4'd0;
            fsm_d = S_DONE;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
      end
      S_DONE: fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge enable) begin
    if (reset) begin
      fsm_q <= S_IDLE;
      st_q  <= '0;
      kp_q  <= '0;
      kc_q  <= '0;
      rnd_q <= '0;
      ct_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      st_q  <= st_d;
      kp_q  <= kp_d;
      kc_q  <= kc_d;
      rnd_q <= rnd_d;
      ct_q  <= ct_d;
    end
  end

  assign busy       = (fsm_q != S_IDLE);
  assign done       = (fsm_q == S_DONE);
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes256_encrypt_iter.sv
// Self-checking bench for aes256_encrypt_iter: transaction-level timing
// model plus a from-scratch AES-256 reference (S-box derived from GF inverse).
module tb_aes256_encrypt_iter;

  localparam logic [255:0] K_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] P_C3 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K_SP =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] P_SP = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C_SP = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;

  logic         enable = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [127:0] plaintext = '0;
  logic [255:0] key = '0;
  logic         busy, done;
  logic [127:0] ciphertext;

  always #5 enable = ~enable;

  aes256_encrypt_iter dut (
    .enable     (enable),
    .reset      (reset),
    .start      (start),
`ifdef AES256_ENC_ABORT_EN
    .abort      (abort),
`endif
    .plaintext  (plaintext),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference AES-256 ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [255:0] k,
                                           input logic [127:0] p);
    logic [31:0] w [60];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [7:0]  a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (i % 8 == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int j = 0; j < 16; j++)
      s[j] = p[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r+4*c] = sb[s[r + 4*((c+r)%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 14) begin
          s[4*c]   = gm(a0,2) ^ gm(a1,3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1,2) ^ gm(a2,3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2,2) ^ gm(a3,3);
          s[4*c+3] = gm(a0,3) ^ a1 ^ a2 ^ gm(a3,2);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int j = 0; j < 16; j++)
        s[j] = s[j] ^ w[4*rnd + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s[j];
    return o;
  endfunction

  // ---------------- transaction timing model ----------------
  int           cyc = 0;
  int           acc = 0;
  bit           live = 0;
  bit           armed = 0;
  logic [127:0] m_ct = '0;
  logic [127:0] m_res = '0;

  always @(posedge enable) begin
    bit idle;
    int d;
    cyc++;
    d = cyc - acc;
    if (reset) begin
      live = 0;
      m_ct = '0;
      armed = 1;
    end else begin
      idle = !live || d >= 16;
      if (live && d >= 1 && d <= 14 && abort) live = 0;
      else if (live && d == 14) m_ct = m_res;
      if (idle && start) begin
        live = 1;
        acc = cyc;
        m_res = aes_ref(key, plaintext);
      end
    end
  end

  always @(negedge enable) begin
    int d;
    bit eb, ed;
    if (armed) begin
      d = cyc - acc;
      eb = live && d <= 14;
      ed = live && d == 14;
      check("busy", 128'(busy), 128'(eb));
      check("done", 128'(done), 128'(ed));
      check("ciphertext", ciphertext, m_ct);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge enable);
  endtask

  task automatic run_one(input logic [255:0] k, input logic [127:0] p,
                         input logic [127:0] c, input string nm);
    int n;
    key = k; plaintext = p; start = 1; tick(); start = 0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin tick(); n++; end
    check({nm, "_latency"}, 128'(n), 128'd14);
    check({nm, "_result"}, ciphertext, c);
    tick();
  endtask

  initial begin
    logic [7:0] inv;
    int n, nd;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rl(inv,1) ^ rl(inv,2) ^ rl(inv,3) ^ rl(inv,4) ^ 8'h63;
    end
    check("model_c3", aes_ref(K_C3, P_C3), C_C3);
    check("model_sp", aes_ref(K_SP, P_SP), C_SP);

    repeat (3) tick();
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_ct", ciphertext, 128'd0);
    reset = 0;

    run_one(K_C3, P_C3, C_C3, "c3");
    run_one(K_SP, P_SP, C_SP, "sp");

    // start re-pulsed with new inputs while busy
    key = K_C3; plaintext = P_C3; start = 1; tick(); start = 0;
    tick(); tick();
    for (int i = 3; i <= 13; i++) begin
      start = 1;
      key = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    start = 0;
    n = 13;
    while (done !== 1'b1 && n < 40) begin tick(); n++; end
    check("repulse_latency", 128'(n), 128'd14);
    check("repulse_result", ciphertext, C_C3);
    tick();

    // reset during round 7
    key = K_C3; plaintext = P_SP; start = 1; tick(); start = 0;
    repeat (6) tick();
    reset = 1; tick(); reset = 0;
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_ct", ciphertext, 128'd0);
    run_one(K_C3, P_C3, C_C3, "after_rst");

    // back-to-back at the earliest legal edge
    key = K_C3; plaintext = P_C3; start = 1; tick();
    key = K_SP; plaintext = P_SP;
    nd = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (done === 1'b1) begin
        nd++;
        check("b2b_first", ciphertext, C_C3);
        check("b2b_first_at", 128'(i), 128'd14);
      end
    end
    start = 0;
    check("b2b_first_count", 128'(nd), 128'd1);
    n = 0;
    while (done !== 1'b1 && n < 40) begin tick(); n++; end
    check("b2b_second_latency", 128'(n), 128'd14);
    check("b2b_second", ciphertext, C_SP);
    tick();

    // randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 700; i++) begin
      start = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 199) == 0);
`ifdef AES256_ENC_ABORT_EN
      abort = ($urandom_range(0, 39) == 0);
`endif
      key = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    start = 0; reset = 0; abort = 0;
    repeat (20) tick();

`ifdef AES256_ENC_ABORT_EN
    run_one(K_C3, P_C3, C_C3, "pre_abort");
    key = K_SP; plaintext = P_SP; start = 1; tick(); start = 0;
    repeat (4) tick();
    abort = 1; tick(); abort = 0;
    check("abort_busy", 128'(busy), 128'd0);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) nd++;
    end
    check("abort_no_done", 128'(nd), 128'd0);
    check("abort_ct", ciphertext, C_C3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
